// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds the RV32I load/store funct3 codes and the responder state encoding.
package dmem_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_responder_lsu_align.sv
// Byte-lane steering for RV32I loads and stores (little-endian, combinational).
// Produces store byte enables and lane data, extended load data and a misalign flag.
module lsu_align
   import dmem_pkg::*;
(
   input  logic [2:0]        funct3_i,
   input  logic [1:0]        addr_lo_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rword_i,
   output logic [3:0]        be_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              misalign_o
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign rhalf = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

   // Store data is replicated across lanes so the byte enable alone picks the target.
   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = '0;
      misalign_o = 1'b0;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o    = {2{wdata_i[15:0]}};
            misalign_o = addr_lo_i[0];
         end
         2'b10: begin
            be_o       = 4'b1111;
            wdata_o    = wdata_i;
            misalign_o = |addr_lo_i;
         end
         default: begin
            be_o       = 4'b0000;
            wdata_o    = '0;
            misalign_o = 1'b0;
         end
      endcase
   end

   always_comb begin
      rdata_o = '0;
      case (funct3_i)
         F3_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
         F3_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
         F3_W:    rdata_o = rword_i;
         F3_BU:   rdata_o = {24'h000000, rbyte};
         F3_HU:   rdata_o = {16'h0000, rhalf};
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, one-cycle response pulse out.
// Holds the request latches, wait counter, sequencing FSM and the word storage.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// WAIT  | request latched, counting down wait states, access at terminal count
// RESP  | rsp_valid high for this one cycle
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                we_q;
   logic [2:0]          funct3_q;
   logic [31:0]         addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                rsp_err_q;

   logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

   logic [IDX_W-1:0]    word_idx;
   logic [DATA_W-1:0]   raw_word;
   logic [3:0]          st_be;
   logic [DATA_W-1:0]   st_data;
   logic [DATA_W-1:0]   ld_data;
   logic                misalign;
   logic                out_of_range;
   logic                acc_err;
   logic                access;
   logic                do_write;

   assign word_idx     = addr_q[IDX_W+1:2];
   assign raw_word     = mem_q[word_idx];
   // Upper address bits take part in the range test so aliasing never hits a real word.
   assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
   assign acc_err      = out_of_range | misalign | ~f3_legal(we_q, funct3_q);
   assign access       = (state_q == WAIT) && (cnt_q == '0);
   assign do_write     = access & we_q & ~acc_err;

   lsu_align u_align (
      .funct3_i   (funct3_q),
      .addr_lo_i  (addr_q[1:0]),
      .wdata_i    (wdata_q),
      .rword_i    (raw_word),
      .be_o       (st_be),
      .wdata_o    (st_data),
      .rdata_o    (ld_data),
      .misalign_o (misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  we_q        <= req_we;
                  funct3_q    <= req_funct3;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  cnt_q       <= CNT_W'(WAIT_STATES);
                  req_ready_q <= 1'b0;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= acc_err;
                  rsp_rdata_q <= (acc_err || we_q) ? '0 : ld_data;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // No reset here: contents survive rst, and rst forces IDLE so no write can fire.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
